fir_sample_feeder: RTL and testbench

- Transmit-side companion to the team's FIR filter.
- Accepts signed samples from an upstream source over a valid/ready handshake and buffers them in a small FIFO.
- Presents each sample on the filter's data/data_ready interface: data is stable one cycle before the data_ready rising edge and is held through the strobe.
- Launch cadence is programmable, so downstream filters clocked on the data_ready edge see clean, evenly spaced strobes.

---
 rtl/fir_sample_feeder.sv | 193 +++++++++++++++++++
 tb/tb_fir_sample_feeder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
//   Transmit-side companion to the FIR filter. Buffers signed samples from an
//   upstream valid/ready source in a small FIFO and replays them on the
//   filter's data/data_ready interface at a programmable frame cadence.
//   A frame is SETUP (1 cycle, data stable, strobe low), STROBE (HIGH_CYCLES
//   cycles, strobe high) and GAP (the remainder of the frame, strobe low).
//
// Ports
//   clk          : rising-edge clock
//   rst          : synchronous reset, active-high
//   in_data      : upstream sample (signed)
//   in_valid     : upstream sample valid
//   in_ready     : FIFO can accept a sample
//   enable       : permit launching frames
//   period       : cycles from one frame start to the next
//   clr_underrun : clears the sticky underrun flag
//   data         : sample toward the filter (signed), changes only on a pop
//   data_ready   : sample strobe; the filter captures on its rising edge
//   level        : FIFO occupancy
//   underrun     : sticky, set when a frame ended with the FIFO empty
module fir_sample_feeder #(
   parameter int DATA_SIZE   = 9,
   parameter int FIFO_DEPTH  = 8,
   parameter int HIGH_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [DATA_SIZE-1:0]   in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          enable,
   input  logic [7:0]                    period,
   input  logic                          clr_underrun,
   output logic signed [DATA_SIZE-1:0]   data,
   output logic                          data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          underrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   // Frame counters are wide enough for any 8-bit period and any practical
   // HIGH_CYCLES value.
   localparam int CW = 16;
   localparam logic [CW-1:0] HIGH_C  = CW'(HIGH_CYCLES);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      GAP
   } state_t;

   // Length of the low tail of a frame: max(period, HIGH_CYCLES+1) minus the
   // SETUP cycle and the strobe itself. Zero means the frame ends straight
   // after the strobe.
   function automatic logic [CW-1:0] gap_len(input logic [7:0] per);
      logic [CW-1:0] per_w;
      logic [CW-1:0] p_eff;
      per_w = {{(CW-8){1'b0}}, per};
      p_eff = (per_w > HIGH_C + 1'b1) ? per_w : HIGH_C + 1'b1;
      return p_eff - HIGH_C - 1'b1;
   endfunction

   logic signed [DATA_SIZE-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]               wr_ptr;
   logic [AW-1:0]               rd_ptr;
   logic                        push;
   logic                        pop;

   state_t        state;
   state_t        state_d;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] gap_q;
   logic [CW-1:0] gap_d;
   logic          frame_end;
   logic          set_unr;

   // ---- FIFO: push side and occupancy ----
   assign in_ready = !rst && (level != DEPTH_C);
   assign push     = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   // Pointers are AW bits wide, so wrap modulo FIFO_DEPTH is implicit.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // ---- Frame sequencer ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         gap_q <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         gap_q <= gap_d;
      end
   end

   always_comb begin
      state_d   = state;
      cnt_d     = cnt + 1'b1;
      gap_d     = gap_q;
      pop       = 1'b0;
      set_unr   = 1'b0;
      frame_end = 1'b0;

      case (state)
         IDLE: begin
            cnt_d = '0;
            if (enable && (level != '0)) begin
               pop     = 1'b1;
               gap_d   = gap_len(period);
               state_d = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = STROBE;
         end
         STROBE: begin
            if (cnt == HIGH_C - 1'b1) begin
               cnt_d = '0;
               if (gap_q != '0)
                  state_d = GAP;
               else
                  frame_end = 1'b1;
            end
         end
         GAP: begin
            if (cnt == gap_q - 1'b1)
               frame_end = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Back-to-back launch keeps the cadence exact: the next SETUP begins
      // one frame length after the previous one.
      if (frame_end) begin
         cnt_d = '0;
         if (enable && (level != '0)) begin
            pop     = 1'b1;
            gap_d   = gap_len(period);
            state_d = SETUP;
         end else begin
            state_d = IDLE;
            set_unr = enable;
         end
      end
   end

   assign data_ready = (state == STROBE);

   // ---- Output sample register: loads only on a pop ----
   always_ff @(posedge clk) begin
      if (rst)
         data <= '0;
      else if (pop)
         data <= mem[rd_ptr];
   end

   // Set has priority over clear.
   always_ff @(posedge clk) begin
      if (rst)
         underrun <= 1'b0;
      else if (set_unr)
         underrun <= 1'b1;
      else if (clr_underrun)
         underrun <= 1'b0;
   end

endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       enable = 1'b0;
   logic [7:0] period = 8'd4;
   logic       clr_underrun = 1'b0;
   logic [8:0] data_o;
   logic       data_ready;
   logic [3:0] level;
   logic       underrun;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   fir_sample_feeder #(
      .DATA_SIZE  (9),
      .FIFO_DEPTH (8),
      .HIGH_CYCLES(1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .enable      (enable),
      .period      (period),
      .clr_underrun(clr_underrun),
      .data        (data_o),
      .data_ready  (data_ready),
      .level       (level),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe recorder: sample value, cycle and underrun flag at each rising edge
   // of data_ready, observed on the falling clock edge.
   logic       dr_q = 1'b0;
   logic [8:0] st_data[$];
   int         st_cyc[$];
   logic       st_unr[$];

   always @(negedge clk) begin
      if (data_ready && !dr_q) begin
         st_data.push_back(data_o);
         st_cyc.push_back(cyc);
         st_unr.push_back(underrun);
      end
      dr_q <= data_ready;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic clear_strobes();
      st_data.delete();
      st_cyc.delete();
      st_unr.delete();
   endtask

   function automatic logic [8:0] pat(input int k);
      int v;
      v = (k * 37) ^ 341;
      return v[8:0];
   endfunction

   typedef struct {
      logic       rst;
      logic       vld;
      logic [8:0] din;
      logic       en;
      logic [7:0] per;
      logic       clr;
      logic [8:0] e_data;
      logic       e_dr;
      logic [3:0] e_lvl;
      logic       e_rdy;
      logic       e_unr;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int  acc;
      bit  ok;
      bit  unr_seen;

      // Each row: inputs for the next edge, outputs expected just after it.
      //            rst  vld  din     en   per  clr   data    dr   lvl  rdy  unr
      tbl[0]  = '{1'b1,1'b0,9'h000,1'b0,8'd4,1'b0, 9'h000,1'b0,4'd0,1'b0,1'b0};
      tbl[1]  = '{1'b1,1'b0,9'h000,1'b0,8'd4,1'b0, 9'h000,1'b0,4'd0,1'b0,1'b0};
      tbl[2]  = '{1'b1,1'b0,9'h000,1'b0,8'd4,1'b0, 9'h000,1'b0,4'd0,1'b0,1'b0};
      tbl[3]  = '{1'b0,1'b0,9'h000,1'b0,8'd4,1'b0, 9'h000,1'b0,4'd0,1'b1,1'b0};
      tbl[4]  = '{1'b0,1'b1,9'h1FB,1'b1,8'd4,1'b0, 9'h000,1'b0,4'd1,1'b1,1'b0};
      tbl[5]  = '{1'b0,1'b0,9'h000,1'b1,8'd4,1'b0, 9'h1FB,1'b0,4'd0,1'b1,1'b0};
      tbl[6]  = '{1'b0,1'b0,9'h000,1'b1,8'd4,1'b0, 9'h1FB,1'b1,4'd0,1'b1,1'b0};
      tbl[7]  = '{1'b0,1'b0,9'h000,1'b1,8'd4,1'b0, 9'h1FB,1'b0,4'd0,1'b1,1'b0};
      tbl[8]  = '{1'b0,1'b0,9'h000,1'b1,8'd4,1'b0, 9'h1FB,1'b0,4'd0,1'b1,1'b0};
      tbl[9]  = '{1'b0,1'b0,9'h000,1'b1,8'd4,1'b0, 9'h1FB,1'b0,4'd0,1'b1,1'b1};
      tbl[10] = '{1'b0,1'b0,9'h000,1'b1,8'd4,1'b1, 9'h1FB,1'b0,4'd0,1'b1,1'b0};
      tbl[11] = '{1'b0,1'b0,9'h000,1'b0,8'd4,1'b0, 9'h1FB,1'b0,4'd0,1'b1,1'b0};

      // ---- Reset/idle and basic launch, table driven ----
      for (int i = 0; i < 12; i++) begin
         rst          = tbl[i].rst;
         in_valid     = tbl[i].vld;
         in_data      = tbl[i].din;
         enable       = tbl[i].en;
         period       = tbl[i].per;
         clr_underrun = tbl[i].clr;
         tick();
         chk($sformatf("row%0d_data", i),  int'(data_o),     int'(tbl[i].e_data));
         chk($sformatf("row%0d_dr", i),    int'(data_ready), int'(tbl[i].e_dr));
         chk($sformatf("row%0d_level", i), int'(level),      int'(tbl[i].e_lvl));
         chk($sformatf("row%0d_rdy", i),   int'(in_ready),   int'(tbl[i].e_rdy));
         chk($sformatf("row%0d_unr", i),   int'(underrun),   int'(tbl[i].e_unr));
      end
      in_valid = 1'b0;
      clr_underrun = 1'b0;

      // ---- Cadence and buffering: period 6, samples 1,2,3 ----
      clear_strobes();
      period = 8'd6;
      enable = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         in_valid = 1'b1;
         in_data  = 9'(k);
         tick();
      end
      in_valid = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (underrun) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("cad_underrun_set", int'(ok), 1);
      chk("cad_count", st_data.size(), 3);
      for (int i = 0; i < 3 && i < st_data.size(); i++)
         chk($sformatf("cad_data%0d", i), int'(st_data[i]), i + 1);
      for (int i = 1; i < 3 && i < st_cyc.size(); i++)
         chk($sformatf("cad_spacing%0d", i), st_cyc[i] - st_cyc[i-1], 6);
      repeat (5) tick();
      chk("cad_idle_no_more", st_data.size(), 3);
      chk("cad_idle_dr", int'(data_ready), 0);
      clr_underrun = 1'b1;
      tick();
      clr_underrun = 1'b0;
      chk("cad_clr_underrun", int'(underrun), 0);

      // ---- Full/backpressure ----
      enable = 1'b0;
      period = 8'd2;
      clear_strobes();
      acc = 0;
      for (int n = 0; n < 10; n++) begin
         in_valid = 1'b1;
         in_data  = 9'(acc);
         ok       = in_ready;
         tick();
         if (ok) acc++;
      end
      in_valid = 1'b0;
      chk("bp_accepted", acc, 8);
      chk("bp_level_full", int'(level), 8);
      chk("bp_ready_low", int'(in_ready), 0);
      enable = 1'b1;
      tick();
      chk("bp_ready_after_pop", int'(in_ready), 1);
      chk("bp_level_after_pop", int'(level), 7);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (underrun) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("bp_drained", int'(ok), 1);
      chk("bp_count", st_data.size(), 8);
      for (int i = 0; i < 8 && i < st_data.size(); i++)
         chk($sformatf("bp_data%0d", i), int'(st_data[i]), i);
      for (int i = 1; i < 8 && i < st_cyc.size(); i++)
         chk($sformatf("bp_spacing%0d", i), st_cyc[i] - st_cyc[i-1], 2);
      enable = 1'b0;
      clr_underrun = 1'b1;
      tick();
      clr_underrun = 1'b0;

      // ---- Minimum period with pointer wrap ----
      period = 8'd0;
      enable = 1'b1;
      clear_strobes();
      acc = 0;
      for (int n = 0; n < 100 && acc < 20; n++) begin
         in_valid = 1'b1;
         in_data  = pat(acc);
         ok       = in_ready;
         tick();
         if (ok) acc++;
      end
      in_valid = 1'b0;
      chk("min_accepted", acc, 20);
      ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if (underrun) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("min_drained", int'(ok), 1);
      chk("min_count", st_data.size(), 20);
      unr_seen = 1'b0;
      for (int i = 0; i < 20 && i < st_data.size(); i++) begin
         chk($sformatf("min_data%0d", i), int'(st_data[i]), int'(pat(i)));
         if (st_unr[i]) unr_seen = 1'b1;
      end
      for (int i = 1; i < 20 && i < st_cyc.size(); i++)
         chk($sformatf("min_spacing%0d", i), st_cyc[i] - st_cyc[i-1], 2);
      chk("min_no_early_underrun", int'(unr_seen), 0);
      enable = 1'b0;
      clr_underrun = 1'b1;
      tick();
      clr_underrun = 1'b0;

      // ---- enable dropped during STROBE ----
      period = 8'd4;
      clear_strobes();
      in_valid = 1'b1;
      in_data  = 9'h0AA;
      tick();
      in_data  = 9'h155;
      tick();
      in_valid = 1'b0;
      enable = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (data_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("en_strobe_seen", int'(ok), 1);
      enable = 1'b0;
      tick();
      chk("en_strobe_width", int'(data_ready), 0);
      repeat (15) tick();
      chk("en_one_strobe", st_data.size(), 1);
      if (st_data.size() > 0)
         chk("en_strobe_data", int'(st_data[0]), 9'h0AA);
      chk("en_level_left", int'(level), 1);
      chk("en_no_underrun", int'(underrun), 0);

      // ---- Reset during GAP with three samples buffered ----
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = pat(40 + k);
         tick();
      end
      in_valid = 1'b0;
      chk("rg_level_before", int'(level), 4);
      period = 8'd8;
      enable = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (data_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("rg_strobe_seen", int'(ok), 1);
      tick();
      chk("rg_in_gap_dr", int'(data_ready), 0);
      chk("rg_in_gap_level", int'(level), 3);
      rst = 1'b1;
      tick();
      chk("rg_level_reset", int'(level), 0);
      chk("rg_dr_reset", int'(data_ready), 0);
      chk("rg_data_reset", int'(data_o), 0);
      chk("rg_ready_in_rst", int'(in_ready), 0);
      rst = 1'b0;
      clear_strobes();
      repeat (20) tick();
      chk("rg_no_strobe", st_data.size(), 0);
      chk("rg_level_after", int'(level), 0);
      chk("rg_underrun_after", int'(underrun), 0);
      chk("rg_ready_after", int'(in_ready), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
